// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: PS/2 mouse command/response byte constants and controller state encoding
package ps2_mouse_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

    typedef enum logic [3:0] {
        IDLE,
        SEND_RST,
        WAIT_ACK1,
        WAIT_BAT,
        WAIT_ID,
        SEND_EN,
        WAIT_ACK2,
        STREAM_B1,
        STREAM_B2,
        STREAM_B3,
        ERROR
    } state_t;

endpackage

// File: rtl/ps2_timeout.sv
// ps2_timeout: loadable response watchdog, one-cycle expired pulse after CYCLES enabled clocks
module ps2_timeout #(
    parameter int CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    // reload on any activity, otherwise count down while the watched state is active
    always_ff @(posedge clk) begin
        if (rst || load)
            cnt <= W'(CYCLES);
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = en && !load && cnt == W'(1);

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// ps2_mouse_ctrl: PS/2 mouse bring-up sequencer and stream packet decoder (watchdog via PS2_MOUSE_TIMEOUT_EN)
module ps2_mouse_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int RESEND_MAX     = 3,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       tx_trig,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    output logic       rx_en,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       init_done,
    output logic       init_err,
    output logic       pkt_valid,
    output logic [2:0] btn,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic       sync_err
);

    localparam int RW = $clog2(RESEND_MAX + 2);

    state_t        state;
    logic [RW-1:0] retry;
    logic [7:0]    b1, b2;
    logic          tmo;

`ifdef PS2_MOUSE_TIMEOUT_EN
    state_t prev;

    // remembers last state so a state entry can reload the watchdog
    always_ff @(posedge clk) prev <= rst ? IDLE : state;

    ps2_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .load    (state != prev || rx_valid || tx_done),
        .en      (!(state inside {IDLE, ERROR, STREAM_B1})),
        .expired (tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    // bring-up sequencing, packet assembly and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            retry     <= '0;
            tx_trig   <= 1'b0;
            tx_byte   <= 8'h00;
            rx_en     <= 1'b0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            pkt_valid <= 1'b0;
            btn       <= 3'b000;
            dx        <= 9'd0;
            dy        <= 9'd0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
            sync_err  <= 1'b0;
            b1        <= 8'h00;
            b2        <= 8'h00;
        end else begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            case (state)
                IDLE, ERROR: begin
                    if (start) begin
                        state    <= SEND_RST;
                        retry    <= '0;
                        init_err <= 1'b0;
                    end
                end
                SEND_RST, SEND_EN: begin
                    if (tx_trig && tx_done) begin
                        tx_trig <= 1'b0;
                        rx_en   <= 1'b1;
                        state   <= (state == SEND_RST) ? WAIT_ACK1 : WAIT_ACK2;
                    end else if (tmo) begin
                        tx_trig  <= 1'b0;
                        init_err <= 1'b1;
                        state    <= ERROR;
                    end else if (!tx_trig) begin
                        tx_trig <= 1'b1;
                        tx_byte <= (state == SEND_RST) ? CMD_RESET : CMD_ENABLE;
                    end
                end
                WAIT_ACK1, WAIT_ACK2: begin
                    if (rx_valid) begin
                        if (rx_byte == RSP_ACK) begin
                            retry     <= '0;
                            init_done <= (state == WAIT_ACK2);
                            state     <= (state == WAIT_ACK1) ? WAIT_BAT : STREAM_B1;
                        end else if (rx_byte == RSP_RESEND && retry != RW'(RESEND_MAX)) begin
                            retry <= retry + 1'b1;
                            rx_en <= 1'b0;
                            state <= (state == WAIT_ACK1) ? SEND_RST : SEND_EN;
                        end else begin
                            rx_en    <= 1'b0;
                            init_err <= 1'b1;
                            state    <= ERROR;
                        end
                    end else if (tmo) begin
                        rx_en    <= 1'b0;
                        init_err <= 1'b1;
                        state    <= ERROR;
                    end
                end
                WAIT_BAT: begin
                    if (rx_valid && rx_byte == RSP_BAT_OK) begin
                        state <= WAIT_ID;
                    end else if (rx_valid || tmo) begin
                        rx_en    <= 1'b0;
                        init_err <= 1'b1;
                        state    <= ERROR;
                    end
                end
                WAIT_ID: begin
                    if (rx_valid) begin
                        rx_en <= 1'b0;
                        state <= SEND_EN;
                    end else if (tmo) begin
                        rx_en    <= 1'b0;
                        init_err <= 1'b1;
                        state    <= ERROR;
                    end
                end
                STREAM_B1: begin
                    if (rx_valid && rx_byte[3]) begin
                        b1    <= rx_byte;
                        state <= STREAM_B2;
                    end else if (rx_valid) begin
                        sync_err <= 1'b1;
                    end
                end
                STREAM_B2: begin
                    if (rx_valid) begin
                        b2    <= rx_byte;
                        state <= STREAM_B3;
                    end else if (tmo) begin
                        sync_err <= 1'b1;
                        state    <= STREAM_B1;
                    end
                end
                STREAM_B3: begin
                    if (rx_valid) begin
                        pkt_valid <= 1'b1;
                        btn       <= b1[2:0];
                        dx        <= {b1[4], b2};
                        dy        <= {b1[5], rx_byte};
                        x_ovf     <= b1[6];
                        y_ovf     <= b1[7];
                        state     <= STREAM_B1;
                    end else if (tmo) begin
                        sync_err <= 1'b1;
                        state    <= STREAM_B1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ps2_mouse_ctrl.md
# ps2_mouse_ctrl

Sequencing controller for the PS/2 mouse link: drives the existing byte transmitter (trigger/done) and byte receiver (enable/complete) to run the full mouse bring-up (reset, self-test, ID, enable data reporting), then assembles the 3-byte stream-mode packets into decoded button and signed-motion outputs. Sits between the PS/2 TX/RX byte engines and the application logic (LED display, cursor), replacing ad-hoc top-level sequencing.

## Interface
Parameters:
- RESEND_MAX, 3: maximum consecutive 8'hFE (resend) replies tolerated per command before ERROR.
- TIMEOUT_CYCLES, 25_000_000: response watchdog length in clk cycles (used only when timeout compiled in).

Ports:
- clk  in  1  system clock (DCM output clock domain).
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin bring-up; sampled only in IDLE or ERROR.
- tx_trig  out  1  request to byte transmitter; held high until tx_done.
- tx_byte  out  8  command byte to transmit; stable while tx_trig high.
- tx_done  in  1  one-cycle pulse, byte sent and acknowledged on the line.
- rx_en  out  1  receiver enable.
- rx_valid  in  1  one-cycle pulse, rx_byte valid.
- rx_byte  in  8  received byte.
- init_done  out  1  high while in stream mode.
- init_err  out  1  high while in ERROR.
- pkt_valid  out  1  one-cycle pulse, packet fields updated.
- btn  out  3  {middle, right, left}.
- dx, dy  out  9 each  two's-complement motion.
- x_ovf, y_ovf  out  1 each  overflow flags of the last packet.
- sync_err  out  1  one-cycle pulse, packet framing error.

## Operation
- States: IDLE, SEND_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2, STREAM_B1, STREAM_B2, STREAM_B3, ERROR.
- IDLE: start -> SEND_RST. ERROR: init_err=1; start -> SEND_RST, retry counter cleared.
- SEND_RST: tx_byte=8'hFF, tx_trig=1; tx_done -> WAIT_ACK1.
- WAIT_ACK1: 8'hFA -> WAIT_BAT; 8'hFE -> SEND_RST, retry+1 (exceeding RESEND_MAX -> ERROR); other byte -> ERROR.
- WAIT_BAT: 8'hAA -> WAIT_ID; any other byte (incl. 8'hFC) -> ERROR.
- WAIT_ID: any byte -> SEND_EN (8'h00 expected, not checked).
- SEND_EN: tx_byte=8'hF4, tx_trig=1; tx_done -> WAIT_ACK2. WAIT_ACK2: 8'hFA -> STREAM_B1, retry cleared; 8'hFE -> SEND_EN with same retry rule; other -> ERROR.
- STREAM_B1: byte with bit3=1 latched as b1 -> STREAM_B2; bit3=0 -> sync_err pulse, byte dropped, stay.
- STREAM_B2: latch b2 -> STREAM_B3. STREAM_B3: latch b3, publish packet -> STREAM_B1.
- Decode: btn=b1[2:0]; dx={b1[4],b2}; dy={b1[5],b3}; x_ovf=b1[6]; y_ovf=b1[7]. Values passed unmodified, no saturation.
- rx_en=1 in all WAIT_* and STREAM_* states, 0 elsewhere; tx_trig never overlaps rx_en.
- Retry counter is separate per command and cleared on leaving the command's WAIT state forward.

## Timing
- Reset: state IDLE; all outputs 0 (tx_byte 8'h00, dx/dy 0); retry counter 0. Reset mid-transfer drops tx_trig on the next edge; partial packet discarded.
- All outputs registered. tx_trig asserts the cycle after entering SEND_*, deasserts the cycle after tx_done.
- pkt_valid one cycle after the third byte's rx_valid; btn/dx/dy/ovf update in that same cycle and hold until next packet.
- init_done rises one cycle after the ACK 8'hFA for F4.
- rx_valid in a SEND_* state is ignored; tx_done outside SEND_* is ignored.

## Configuration
- PS2_MOUSE_TIMEOUT_EN defined: watchdog counter reloads on every state entry and every rx_valid/tx_done. Expiry in SEND_*/WAIT_* -> ERROR; expiry in STREAM_B2/B3 -> sync_err pulse, partial packet dropped, -> STREAM_B1. No timeout in IDLE, ERROR, STREAM_B1.
- Undefined: no counter, states wait indefinitely; TIMEOUT_CYCLES unused.

## Structure
- Shared package ps2_mouse_pkg: command constants (FF reset, F4 enable), response constants (FA ack, FE resend, AA BAT pass, FC BAT fail), state encoding.
- Sub-module ps2_timeout (loadable down-counter with expiry pulse), instantiated only under PS2_MOUSE_TIMEOUT_EN.

## Test plan
- Normal bring-up: start; tx_done; FA, AA, 00; tx_done; FA -> tx bytes FF then F4, init_done=1, init_err=0.
- Packet: bytes 8'h19, 8'h05, 8'hFE -> pkt_valid once, btn=3'b001, dx=-251 (9'h105), dy=+254 (9'h0FE).
- Resend: FE reply to FF four times with RESEND_MAX=3 -> FF transmitted 4 times, then ERROR, init_err=1; start recovers.
- Framing: in stream, byte 8'h00 then 8'h08,8'h01,8'h02 -> one sync_err, then pkt_valid with dx=1, dy=2.
- BAT failure: reply FC in WAIT_BAT -> ERROR, rx_en=0, tx_trig=0.
- Reset mid-packet after two bytes: rst one cycle -> all outputs 0, IDLE; stray rx_valid ignored.
